int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt sequencer between the external `int` pin and the fetch stage of the 8-bit pipelined core.
- Synchronises and edge-detects the request, then waits for any in-flight branch flush to finish and drains the pipeline.
- Pushes the return PC to the stack (R3 = SP), shadows the CCR, loads PC from the vector at M[1] and stalls fetch throughout.
- Handles RTI: pops PC, restores CCR, and returns the core to normal flow.

Parameters:
- SYNC_STAGES, 2, flops in the `int_in` synchroniser (≥2).
- DRAIN_CYCLES, 3, stall cycles held before the stack push so older instructions retire.
- VEC_ADDR, 8'h01, memory address holding the ISR start address.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- int_in  in  1  raw external interrupt, asynchronous level.
- flush_in  in  1  pipeline flush in progress (taken branch); blocks acceptance.
- rti_req  in  1  single-cycle pulse: RTI decoded.
- pc_next  in  8  address of next instruction to fetch (return address).
- sp_in  in  8  current R3 value.
- ccr_in  in  4  current flags {V,C,N,Z}.
- mem_rdata  in  8  data-memory read data; synchronous, 1-cycle latency.
- stall_fetch  out  1  freeze PC/IF-ID.
- pc_load  out  1  load PC with pc_load_val this edge.
- pc_load_val  out  8  new PC value.
- sp_we  out  1  write R3.
- sp_wdata  out  8  new R3 value.
- mem_re  out  1  read request; ctrl owns the port when asserted.
- mem_we  out  1  write request.
- mem_addr  out  8  memory address.
- mem_wdata  out  8  memory write data.
- ccr_restore  out  1  load CCR from ccr_out.
- ccr_out  out  4  shadowed flags.
- int_active  out  1  high while in ISR.

Behaviour:
- Reset (async, any state):
  - state = IDLE; synchroniser, edge register, pending flag, drain counter and shadows cleared.
  - All outputs 0.
- Synchroniser: SYNC_STAGES flops, then rising-edge detect.
  - The edge sets `pending` (sticky, 1-deep).
  - `pending` clears on the IDLE→DRAIN transition.
  - Level held high generates exactly one request.
- Arithmetic: SP ±1 wraps mod 256 (0x00−1 = 0xFF, 0xFF+1 = 0x00).
- IDLE: if `pending` & !flush_in → DRAIN.
  - On this transition latch ret_pc = pc_next and load the counter with DRAIN_CYCLES.
  - If flush_in is high, wait; `pending` is held.
- DRAIN: stall_fetch = 1; decrement counter each cycle; at 0 → PUSH. Duration is exactly DRAIN_CYCLES cycles.
- PUSH (1 cycle):
  - stall = 1; mem_we = 1, mem_addr = sp_in, mem_wdata = ret_pc.
  - sp_we = 1, sp_wdata = sp_in − 1; ccr_shadow ← ccr_in.
  - → VEC_RD.
- VEC_RD (1 cycle): stall = 1; mem_re = 1, mem_addr = VEC_ADDR; → VEC_LD.
- VEC_LD (1 cycle): stall = 1; pc_load = 1, pc_load_val = mem_rdata; → ISR.
- ISR: stall = 0; int_active = 1.
  - New edges set `pending` but are not taken (no nesting).
  - rti_req → POP.
- POP (1 cycle):
  - stall = 1; mem_re = 1, mem_addr = sp_in + 1.
  - sp_we = 1, sp_wdata = sp_in + 1.
  - → RET_LD.
- RET_LD (1 cycle):
  - stall = 1; pc_load = 1, pc_load_val = mem_rdata.
  - ccr_restore = 1, ccr_out = ccr_shadow.
  - → IDLE. int_active drops on entry to IDLE.
  - A held `pending` is accepted from IDLE on the following cycle (subject to flush_in).
- rti_req outside ISR: ignored, no outputs asserted.
- Simultaneous edge and rti_req in ISR: RTI proceeds; the edge is latched as pending.
- Outputs are Moore (decoded from state/registers). All non-listed outputs are 0 in each state.
- Entry latency: edge-to-VEC_LD = SYNC_STAGES + 1 + DRAIN_CYCLES + 3 cycles.
- Reset mid-sequence: abandons immediately. No further mem/sp/pc strobes; no partial-restore obligations.

Test Plan:
- Entry, default params: sp_in = 0xFF, pc_next = 0x05, M[1] = 0xB0, ccr_in = 4'b0100, pulse int_in.
  - mem write M[0xFF] = 0x05.
  - sp_wdata = 0xFE.
  - pc_load with 0xB0 exactly 9 cycles after the edge.
  - stall_fetch high for the 6 cycles DRAIN..VEC_LD.
  - int_active = 1 after.
- RTI: in ISR, sp_in = 0xFE, M[0xFF] = 0x05, ccr_in changed to 4'b0001; pulse rti_req.
  - POP reads addr 0xFF; sp_wdata = 0xFF.
  - Next cycle pc_load_val = 0x05, ccr_restore with ccr_out = 4'b0100.
  - int_active = 0.
- Flush blocking: raise flush_in for 4 cycles overlapping the pending cycle → DRAIN entered only the cycle after flush_in falls; ret_pc equals pc_next of that cycle.
- Held level and nesting:
  - int_in held high 20 cycles → one entry only.
  - A second pulse during ISR → no stall until RTI completes, then a second entry follows with push at sp_in.
- SP wrap: sp_in = 0x00 on entry → write M[0x00], sp_wdata = 0xFF. RTI with sp_in = 0xFF → read M[0x00], sp_wdata = 0x00.
- Async reset in VEC_RD: rst pulse mid-cycle → all outputs 0 immediately (before next edge); state IDLE; a prior pending edge is discarded.

Source files
------------

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt entry/return sequencer between the int pin and fetch
// Registered strobes come from the FSM; address/data buses are decoded from state.
module int_ctrl #(
   parameter int         SYNC_STAGES  = 2,
   parameter int         DRAIN_CYCLES = 3,
   parameter logic [7:0] VEC_ADDR     = 8'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       int_in,
   input  logic       flush_in,
   input  logic       rti_req,
   input  logic [7:0] pc_next,
   input  logic [7:0] sp_in,
   input  logic [3:0] ccr_in,
   input  logic [7:0] mem_rdata,
   output logic       stall_fetch,
   output logic       pc_load,
   output logic [7:0] pc_load_val,
   output logic       sp_we,
   output logic [7:0] sp_wdata,
   output logic       mem_re,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       ccr_restore,
   output logic [3:0] ccr_out,
   output logic       int_active
);

   localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE, DRAIN, PUSH, VEC_RD, VEC_LD, ISR, POP, RET_LD
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_q;
   logic                   pending;
   logic [CW-1:0]          drain_cnt;
   logic [7:0]             ret_pc;
   logic [3:0]             ccr_shadow;
   logic                   rise;

   assign rise = sync[SYNC_STAGES-1] & ~sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sync        <= '0;
         sync_q      <= 1'b0;
         pending     <= 1'b0;
         drain_cnt   <= '0;
         ret_pc      <= '0;
         ccr_shadow  <= '0;
         stall_fetch <= 1'b0;
         pc_load     <= 1'b0;
         sp_we       <= 1'b0;
         mem_re      <= 1'b0;
         mem_we      <= 1'b0;
         ccr_restore <= 1'b0;
         int_active  <= 1'b0;
      end else begin
         sync        <= {sync[SYNC_STAGES-2:0], int_in};
         sync_q      <= sync[SYNC_STAGES-1];
         stall_fetch <= 1'b0;
         pc_load     <= 1'b0;
         sp_we       <= 1'b0;
         mem_re      <= 1'b0;
         mem_we      <= 1'b0;
         ccr_restore <= 1'b0;
         int_active  <= 1'b0;
         // Each branch sets the strobes belonging to the state being entered.
         case (state)
            IDLE: begin
               if (pending && !flush_in) begin
                  state       <= DRAIN;
                  ret_pc      <= pc_next;
                  drain_cnt   <= CW'(DRAIN_CYCLES);
                  pending     <= 1'b0;
                  stall_fetch <= 1'b1;
               end
            end
            DRAIN: begin
               stall_fetch <= 1'b1;
               if (drain_cnt != '0) drain_cnt <= drain_cnt - CW'(1);
               if (drain_cnt <= CW'(1)) begin
                  state  <= PUSH;
                  mem_we <= 1'b1;
                  sp_we  <= 1'b1;
               end
            end
            PUSH: begin
               state       <= VEC_RD;
               ccr_shadow  <= ccr_in;
               stall_fetch <= 1'b1;
               mem_re      <= 1'b1;
            end
            VEC_RD: begin
               state       <= VEC_LD;
               stall_fetch <= 1'b1;
               pc_load     <= 1'b1;
            end
            VEC_LD: begin
               state      <= ISR;
               int_active <= 1'b1;
            end
            ISR: begin
               int_active <= 1'b1;
               if (rti_req) begin
                  state       <= POP;
                  stall_fetch <= 1'b1;
                  mem_re      <= 1'b1;
                  sp_we       <= 1'b1;
               end
            end
            POP: begin
               state       <= RET_LD;
               stall_fetch <= 1'b1;
               pc_load     <= 1'b1;
               ccr_restore <= 1'b1;
               int_active  <= 1'b1;
            end
            RET_LD: state <= IDLE;
            default: state <= IDLE;
         endcase
         // A new edge wins over the clear on acceptance so it is not lost.
         if (rise) pending <= 1'b1;
      end
   end

   always_comb begin
      pc_load_val = '0;
      sp_wdata    = '0;
      mem_addr    = '0;
      mem_wdata   = '0;
      ccr_out     = '0;
      case (state)
         PUSH: begin
            mem_addr  = sp_in;
            mem_wdata = ret_pc;
            sp_wdata  = sp_in - 8'd1;
         end
         VEC_RD: mem_addr = VEC_ADDR;
         VEC_LD: pc_load_val = mem_rdata;
         POP: begin
            mem_addr = sp_in + 8'd1;
            sp_wdata = sp_in + 8'd1;
         end
         RET_LD: begin
            pc_load_val = mem_rdata;
            ccr_out     = ccr_shadow;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl with a schedule-based reference model
module tb_int_ctrl;

   localparam int         SYNC  = 2;
   localparam int         DRAIN = 3;
   localparam logic [7:0] VEC   = 8'h01;

   localparam int M_IDLE  = 0;
   localparam int M_ENTER = 1;
   localparam int M_ISR   = 2;
   localparam int M_RET   = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       int_in, flush_in, rti_req;
   logic [7:0] pc_next, sp_in, mem_rdata;
   logic [3:0] ccr_in;
   logic       stall_fetch, pc_load, sp_we, mem_re, mem_we, ccr_restore, int_active;
   logic [7:0] pc_load_val, sp_wdata, mem_addr, mem_wdata;
   logic [3:0] ccr_out;

   int_ctrl #(.SYNC_STAGES(SYNC), .DRAIN_CYCLES(DRAIN), .VEC_ADDR(VEC)) dut (
      .clk(clk), .rst(rst), .int_in(int_in), .flush_in(flush_in), .rti_req(rti_req),
      .pc_next(pc_next), .sp_in(sp_in), .ccr_in(ccr_in), .mem_rdata(mem_rdata),
      .stall_fetch(stall_fetch), .pc_load(pc_load), .pc_load_val(pc_load_val),
      .sp_we(sp_we), .sp_wdata(sp_wdata), .mem_re(mem_re), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ccr_restore(ccr_restore),
      .ccr_out(ccr_out), .int_active(int_active)
   );

   always #5 clk = ~clk;

   wire [42:0] obs_v = {stall_fetch, pc_load, pc_load_val, sp_we, sp_wdata, mem_re, mem_we,
                        mem_addr, mem_wdata, ccr_restore, ccr_out, int_active};

   int errors;
   int checks;
   int cyc;
   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];

   int          m_mode, m_t0;
   logic        m_pend;
   logic [7:0]  m_ret, m_vec_val, m_pop_val;
   logic [3:0]  m_shadow;
   logic [SYNC+1:0] m_hist;

   logic       s_stall, s_pcl, s_spwe, s_re, s_we, s_ccrr, s_act;
   logic [7:0] s_pcv, s_spw, s_addr, s_wd;
   logic [3:0] s_ccr;

   int found, at_c, edge_c, nstall, nwe, settled;
   logic [7:0] cap8, cap8b;

   function automatic logic [7:0] wrap8(input int v);
      return 8'(v & 32'hFF);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_pend = 1'b0;
      m_hist = '0;
      m_t0   = 0;
   endtask

   // One clock: compare outputs against the schedule, respond as memory, advance the model.
   task automatic run_cycle();
      logic       e_stall, e_pcl, e_spwe, e_re, e_we, e_ccrr, e_act, nxt_pend;
      logic [7:0] e_pcv, e_spw, e_addr, e_wd, resp;
      logic [3:0] e_ccr;
      int         off;
      @(negedge clk);
      {e_stall, e_pcl, e_spwe, e_re, e_we, e_ccrr, e_act} = '0;
      {e_pcv, e_spw, e_addr, e_wd, e_ccr} = '0;
      off = cyc - m_t0;
      case (m_mode)
         M_ENTER: begin
            e_stall = 1'b1;
            if (off == DRAIN) begin
               e_we = 1'b1; e_addr = sp_in; e_wd = m_ret;
               e_spwe = 1'b1; e_spw = wrap8(int'(sp_in) - 1);
            end else if (off == DRAIN + 1) begin
               e_re = 1'b1; e_addr = VEC;
            end else if (off == DRAIN + 2) begin
               e_pcl = 1'b1; e_pcv = m_vec_val;
            end
         end
         M_ISR: e_act = 1'b1;
         M_RET: begin
            e_stall = 1'b1; e_act = 1'b1;
            if (off == 0) begin
               e_re = 1'b1; e_addr = wrap8(int'(sp_in) + 1);
               e_spwe = 1'b1; e_spw = wrap8(int'(sp_in) + 1);
            end else begin
               e_pcl = 1'b1; e_pcv = m_pop_val; e_ccrr = 1'b1; e_ccr = m_shadow;
            end
         end
         default: ;
      endcase
      chk($sformatf("outputs@%0d", cyc), 64'(obs_v),
          64'({e_stall, e_pcl, e_pcv, e_spwe, e_spw, e_re, e_we, e_addr, e_wd, e_ccrr, e_ccr, e_act}));
      {s_stall, s_pcl, s_pcv, s_spwe, s_spw, s_re, s_we, s_addr, s_wd, s_ccrr, s_ccr, s_act} = obs_v;

      if (mem_we) mem[mem_addr] = mem_wdata;
      resp = mem_re ? mem[mem_addr] : 8'($urandom);

      nxt_pend = m_pend;
      case (m_mode)
         M_IDLE: if (m_pend && !flush_in) begin
            m_mode = M_ENTER; m_t0 = cyc + 1; m_ret = pc_next; nxt_pend = 1'b0;
         end
         M_ENTER: begin
            if (off == DRAIN) begin
               ref_mem[sp_in] = m_ret;
               m_shadow = ccr_in;
            end
            if (off == DRAIN + 1) m_vec_val = ref_mem[VEC];
            if (off == DRAIN + 2) m_mode = M_ISR;
         end
         M_ISR: if (rti_req) begin
            m_mode = M_RET; m_t0 = cyc + 1;
         end
         M_RET: begin
            if (off == 0) m_pop_val = ref_mem[wrap8(int'(sp_in) + 1)];
            else m_mode = M_IDLE;
         end
         default: ;
      endcase
      m_hist = {m_hist[SYNC:0], int_in};
      if (m_hist[SYNC] && !m_hist[SYNC+1]) nxt_pend = 1'b1;
      m_pend = nxt_pend;

      @(posedge clk);
      #1;
      mem_rdata = resp;
      cyc++;
   endtask

   task automatic pulse_int();
      int_in = 1'b1;
      run_cycle();
      int_in = 1'b0;
   endtask

   task automatic wait_isr(input string tag);
      int ok;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         run_cycle();
         if (s_act && !s_stall) begin
            ok = 1;
            break;
         end
      end
      chk(tag, 64'(ok), 64'd1);
   endtask

   task automatic do_rti();
      rti_req = 1'b1;
      run_cycle();
      rti_req = 1'b0;
      run_cycle();
      run_cycle();
   endtask

   task automatic wait_push(input string tag);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         run_cycle();
         if (s_we) begin
            found = 1;
            break;
         end
      end
      chk(tag, 64'(found), 64'd1);
   endtask

   initial begin
      errors = 0; checks = 0; cyc = 0;
      rst = 1'b1; int_in = 1'b0; flush_in = 1'b0; rti_req = 1'b0;
      pc_next = '0; sp_in = '0; ccr_in = '0; mem_rdata = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[VEC] = 8'hB0;
      ref_mem[VEC] = 8'hB0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'(obs_v), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Entry with default parameters
      sp_in = 8'hFF; pc_next = 8'h05; ccr_in = 4'b0100;
      repeat (2) run_cycle();
      edge_c = cyc;
      pulse_int();
      found = 0; nstall = 0; at_c = -1; cap8 = '0; cap8b = '0;
      for (int i = 0; i < 30; i++) begin
         run_cycle();
         if (s_stall) nstall++;
         if (s_we) cap8b = s_spw;
         if (s_pcl) begin
            found = 1; at_c = cyc - 1; cap8 = s_pcv;
            break;
         end
      end
      chk("entry_found", 64'(found), 64'd1);
      chk("entry_latency", 64'(at_c - edge_c), 64'd9);
      chk("entry_vector", 64'(cap8), 64'hB0);
      chk("entry_stall_cycles", 64'(nstall), 64'd6);
      chk("push_mem_ff", 64'(mem[8'hFF]), 64'h05);
      chk("push_sp_wdata", 64'(cap8b), 64'hFE);
      run_cycle();
      chk("isr_active", 64'(s_act), 64'd1);
      chk("isr_no_stall", 64'(s_stall), 64'd0);

      // Return from interrupt
      sp_in = 8'hFE; ccr_in = 4'b0001;
      run_cycle();
      rti_req = 1'b1;
      run_cycle();
      rti_req = 1'b0;
      run_cycle();
      chk("pop_re", 64'(s_re), 64'd1);
      chk("pop_addr", 64'(s_addr), 64'hFF);
      chk("pop_sp_wdata", 64'(s_spw), 64'hFF);
      sp_in = 8'hFF;
      run_cycle();
      chk("ret_pc", 64'(s_pcv), 64'h05);
      chk("ret_ccr_restore", 64'(s_ccrr), 64'd1);
      chk("ret_ccr", 64'(s_ccr), 64'b0100);
      run_cycle();
      chk("ret_inactive", 64'(s_act), 64'd0);

      // Flush blocks acceptance; pending waits for it to fall
      repeat (3) run_cycle();
      edge_c = cyc;
      pulse_int();
      flush_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pc_next = 8'(32'h40 + cyc);
         run_cycle();
      end
      flush_in = 1'b0;
      found = 0; at_c = -1;
      for (int i = 0; i < 10; i++) begin
         pc_next = 8'(32'h40 + cyc);
         run_cycle();
         if (s_stall) begin
            found = 1; at_c = cyc - 1;
            break;
         end
      end
      chk("flush_accept_cycle", 64'(at_c - edge_c), 64'd6);
      wait_push("flush_push_seen");
      chk("flush_ret_pc", 64'(s_wd), 64'(8'(32'h40 + edge_c + 5)));
      wait_isr("flush_isr");
      do_rti();

      // Level held high yields exactly one entry
      nwe = 0;
      int_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         run_cycle();
         if (s_we) nwe++;
      end
      int_in = 1'b0;
      wait_isr("held_isr");
      do_rti();
      for (int i = 0; i < 15; i++) begin
         run_cycle();
         if (s_we) nwe++;
      end
      chk("held_level_entries", 64'(nwe), 64'd1);

      // No nesting: an edge during ISR waits for RTI, then re-enters
      pulse_int();
      wait_isr("nest_isr1");
      pulse_int();
      nstall = 0;
      for (int i = 0; i < 10; i++) begin
         run_cycle();
         if (s_stall) nstall++;
      end
      chk("nest_no_stall", 64'(nstall), 64'd0);
      sp_in = 8'h80;
      do_rti();
      wait_push("nest_second_push");
      chk("nest_push_addr", 64'(s_addr), 64'h80);
      wait_isr("nest_isr2");
      do_rti();

      // Stack pointer wrap in both directions
      sp_in = 8'h00; pc_next = 8'h3C;
      pulse_int();
      wait_push("wrap_push_seen");
      chk("wrap_push_addr", 64'(s_addr), 64'h00);
      chk("wrap_push_sp", 64'(s_spw), 64'hFF);
      chk("wrap_push_data", 64'(s_wd), 64'h3C);
      wait_isr("wrap_isr");
      sp_in = 8'hFF;
      rti_req = 1'b1;
      run_cycle();
      rti_req = 1'b0;
      run_cycle();
      chk("wrap_pop_addr", 64'(s_addr), 64'h00);
      chk("wrap_pop_sp", 64'(s_spw), 64'h00);
      run_cycle();
      chk("wrap_ret_pc", 64'(s_pcv), 64'h3C);

      // Randomised traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 11) == 0) int_in = ~int_in;
         flush_in = ($urandom_range(0, 3) == 0);
         rti_req  = ($urandom_range(0, 5) == 0);
         pc_next  = 8'($urandom);
         sp_in    = 8'($urandom);
         ccr_in   = 4'($urandom);
         run_cycle();
      end
      int_in = 1'b0; flush_in = 1'b0; rti_req = 1'b0;
      settled = 0;
      for (int i = 0; i < 200; i++) begin
         rti_req = (m_mode == M_ISR);
         run_cycle();
         if (i > SYNC + 3 && m_mode == M_IDLE && !m_pend) begin
            settled = 1;
            break;
         end
      end
      rti_req = 1'b0;
      chk("random_settle", 64'(settled), 64'd1);

      // Asynchronous reset in VEC_RD with a further edge pending
      sp_in = 8'h50;
      pulse_int();
      found = 0;
      for (int i = 0; i < 20; i++) begin
         run_cycle();
         if (m_mode == M_ENTER) begin
            found = 1;
            break;
         end
      end
      chk("rst_entry_seen", 64'(found), 64'd1);
      pulse_int();
      for (int i = 0; i < 10; i++) begin
         if (m_mode == M_ENTER && cyc - m_t0 == DRAIN + 1) break;
         run_cycle();
      end
      chk("rst_in_vec_rd", 64'(mem_re), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_outputs", 64'(obs_v), 64'd0);
      #1;
      rst = 1'b0;
      model_reset();
      nstall = 0;
      for (int i = 0; i < 20; i++) begin
         run_cycle();
         if (s_stall || s_re || s_we) nstall++;
      end
      chk("rst_pending_discarded", 64'(nstall), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
